// File: rtl/PKG_pwm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | PKG_pwm : shared PWM control-field types and carrier width          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

package PKG_pwm;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  typedef enum logic [1:0] {
    CNT_UP     = 2'd0,
    CNT_DOWN   = 2'd1,
    CNT_UPDOWN = 2'd2,
    CNT_HOLD   = 2'd3
  } _count_mode;

  typedef enum logic {
    CLKDIV_OFF = 1'b0,
    CLKDIV_ON  = 1'b1
  } _clkdiv_onoff;

  typedef enum logic {
    INT_OFF = 1'b0,
    INT_ON  = 1'b1
  } _int_onoff;

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_prescaler : tick every clkdiv+1 cycles when enabled, else always|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module pwm_prescaler #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] clkdiv,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 w_wrap;

  // >= keeps the counter bounded if clkdiv is lowered while running
  assign w_wrap = (r_cnt >= clkdiv);
  assign tick   = !en || w_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!en || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_carrier_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pwm_carrier_counter : up/down/up-down PWM carrier with event pulses |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module pwm_carrier_counter
  import PKG_pwm::*;
#(
  parameter int CNT_WIDTH = `PWMCOUNT_WIDTH,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  _pwm_onoff            pwm_onoff,
  input  _count_mode           count_mode,
  input  _clkdiv_onoff         pwmclkdiv_onoff,
  input  _int_onoff            int_onoff,
  input  logic [DIV_WIDTH-1:0] clkdiv,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic                 irq_clr,
  output logic [CNT_WIDTH-1:0] carrier,
  output logic                 dir_down,
  output logic                 zero_evt,
  output logic                 max_evt,
  output logic                 shadow_load,
  output logic                 irq
);

  logic [CNT_WIDTH-1:0] r_carrier;
  logic [CNT_WIDTH-1:0] r_period_act;
  _count_mode           r_mode_act;
  logic                 r_dir_down;
  logic                 r_zero_evt;
  logic                 r_max_evt;
  logic                 r_shadow_load;
  logic                 r_irq;

  logic                 w_run;
  logic                 w_tick;
  logic                 w_step;
  logic [CNT_WIDTH-1:0] w_next_carrier;
  logic                 w_next_dir;
  logic                 w_zero;
  logic                 w_max;
  logic                 w_irq_set;

  assign w_run = (pwm_onoff == PWM_ON);

  pwm_prescaler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (w_run && (pwmclkdiv_onoff == CLKDIV_ON)),
    .clkdiv (clkdiv),
    .tick   (w_tick)
  );

  always_comb begin
    w_next_carrier = r_carrier;
    w_next_dir     = r_dir_down;
    case (r_mode_act)
      CNT_UP: begin
        w_next_dir     = 1'b0;
        w_next_carrier = (r_carrier >= r_period_act) ? '0 : r_carrier + 1'b1;
      end
      CNT_DOWN: begin
        w_next_dir     = 1'b1;
        w_next_carrier = (r_carrier == '0) ? r_period_act : r_carrier - 1'b1;
      end
      CNT_UPDOWN: begin
        // A zero carrier always restarts upward, so a stale dir_down never underflows
        if (!(r_dir_down && (r_carrier != '0)) && (r_carrier < r_period_act)) begin
          w_next_carrier = r_carrier + 1'b1;
          w_next_dir     = (w_next_carrier == r_period_act);
        end else begin
          w_next_carrier = (r_carrier == '0) ? '0 : r_carrier - 1'b1;
          w_next_dir     = (w_next_carrier != '0);
        end
      end
      default: begin
        w_next_carrier = r_carrier;
        w_next_dir     = r_dir_down;
      end
    endcase
  end

  assign w_step    = w_run && w_tick && (r_mode_act != CNT_HOLD);
  assign w_zero    = w_step && (w_next_carrier == '0);
  assign w_max     = w_step && (w_next_carrier == r_period_act) && (r_period_act != '0);
  assign w_irq_set = w_zero && (int_onoff == INT_ON);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_carrier     <= '0;
      r_period_act  <= '0;
      r_mode_act    <= CNT_UP;
      r_dir_down    <= 1'b0;
      r_zero_evt    <= 1'b0;
      r_max_evt     <= 1'b0;
      r_shadow_load <= 1'b0;
      r_irq         <= 1'b0;
    end else begin
      r_zero_evt    <= 1'b0;
      r_max_evt     <= 1'b0;
      r_shadow_load <= 1'b0;
      if (!w_run) begin
        r_carrier    <= '0;
        r_dir_down   <= 1'b0;
        r_period_act <= period;
        r_mode_act   <= count_mode;
      end else if (w_step) begin
        r_carrier  <= w_next_carrier;
        r_dir_down <= w_next_dir;
        r_zero_evt <= w_zero;
        r_max_evt  <= w_max;
        if (w_zero) begin
          r_period_act  <= period;
          r_mode_act    <= count_mode;
          r_shadow_load <= 1'b1;
        end
      end
      r_irq <= w_irq_set | (r_irq & ~irq_clr);
    end
  end

  assign carrier     = r_carrier;
  assign dir_down    = r_dir_down;
  assign zero_evt    = r_zero_evt;
  assign max_evt     = r_max_evt;
  assign shadow_load = r_shadow_load;
  assign irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_pwm_carrier_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pwm_carrier_counter : directed scoreboard bench for the carrier  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_pwm_carrier_counter;
  import PKG_pwm::*;

  logic         clk = 1'b0;
  logic         rst_n;
  _pwm_onoff    pwm_onoff;
  _count_mode   count_mode;
  _clkdiv_onoff pwmclkdiv_onoff;
  _int_onoff    int_onoff;
  logic [7:0]   clkdiv;
  logic [15:0]  period;
  logic         irq_clr;
  logic [15:0]  carrier;
  logic         dir_down;
  logic         zero_evt;
  logic         max_evt;
  logic         shadow_load;
  logic         irq;

  always #5 clk = ~clk;

  pwm_carrier_counter #(
    .CNT_WIDTH (16),
    .DIV_WIDTH (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pwm_onoff       (pwm_onoff),
    .count_mode      (count_mode),
    .pwmclkdiv_onoff (pwmclkdiv_onoff),
    .int_onoff       (int_onoff),
    .clkdiv          (clkdiv),
    .period          (period),
    .irq_clr         (irq_clr),
    .carrier         (carrier),
    .dir_down        (dir_down),
    .zero_evt        (zero_evt),
    .max_evt         (max_evt),
    .shadow_load     (shadow_load),
    .irq             (irq)
  );

  typedef struct {
    logic [20:0] v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Expected state after the next rising edge: carrier, dir, zero, max, shadow, irq
  task automatic step(input string tag, input logic [15:0] c, input logic d, input logic z,
                      input logic m, input logic s, input logic i);
    exp_t        e;
    logic [20:0] obs;
    e.v   = {c, d, z, m, s, i};
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    obs = {carrier, dir_down, zero_evt, max_evt, shadow_load, irq};
    checks++;
    assert (obs === e.v) else begin
      failures++;
      $error("FAIL %s: observed carrier=%0d dir/zero/max/shadow/irq=%b expected carrier=%0d dir/zero/max/shadow/irq=%b",
             e.tag, obs[20:5], obs[4:0], e.v[20:5], e.v[4:0]);
    end
  endtask

  // One prescaled step with clkdiv=2: value appears, then holds two more cycles
  task automatic tick_div(input string tag, input logic [15:0] c, input logic d, input logic z,
                          input logic m, input logic s, input logic i);
    step(tag, c, d, z, m, s, i);
    repeat (2) step({tag, "_hold"}, c, d, 1'b0, 1'b0, 1'b0, i);
  endtask

  initial begin
    rst_n           = 1'b0;
    pwm_onoff       = PWM_OFF;
    count_mode      = CNT_UP;
    pwmclkdiv_onoff = CLKDIV_OFF;
    int_onoff       = INT_OFF;
    clkdiv          = 8'd0;
    period          = 16'd0;
    irq_clr         = 1'b0;
    step("reset", 16'd0, 0, 0, 0, 0, 0);

    // UP, P=3, no prescale, interrupt disabled
    rst_n  = 1'b1;
    period = 16'd3;
    step("up_idle", 16'd0, 0, 0, 0, 0, 0);
    pwm_onoff = PWM_ON;
    step("up_1", 16'd1, 0, 0, 0, 0, 0);
    step("up_2", 16'd2, 0, 0, 0, 0, 0);
    step("up_3_max", 16'd3, 0, 0, 1, 0, 0);
    step("up_0_zero", 16'd0, 0, 1, 0, 1, 0);
    step("up_1b", 16'd1, 0, 0, 0, 0, 0);
    step("up_2b", 16'd2, 0, 0, 0, 0, 0);
    pwm_onoff = PWM_OFF;
    step("off_mid", 16'd0, 0, 0, 0, 0, 0);
    step("off_quiet", 16'd0, 0, 0, 0, 0, 0);

    // UPDOWN, P=4, prescaler clkdiv=2, interrupt enabled
    count_mode      = CNT_UPDOWN;
    period          = 16'd4;
    clkdiv          = 8'd2;
    pwmclkdiv_onoff = CLKDIV_ON;
    int_onoff       = INT_ON;
    step("ud_idle", 16'd0, 0, 0, 0, 0, 0);
    pwm_onoff = PWM_ON;
    repeat (2) step("ud_pre", 16'd0, 0, 0, 0, 0, 0);
    tick_div("ud_1", 16'd1, 0, 0, 0, 0, 0);
    tick_div("ud_2", 16'd2, 0, 0, 0, 0, 0);
    tick_div("ud_3", 16'd3, 0, 0, 0, 0, 0);
    tick_div("ud_4_max", 16'd4, 1, 0, 1, 0, 0);
    tick_div("ud_3d", 16'd3, 1, 0, 0, 0, 0);
    tick_div("ud_2d", 16'd2, 1, 0, 0, 0, 0);
    tick_div("ud_1d", 16'd1, 1, 0, 0, 0, 0);
    tick_div("ud_0_irq", 16'd0, 0, 1, 0, 1, 1);
    pwm_onoff = PWM_OFF;
    step("ud_off_irq_kept", 16'd0, 0, 0, 0, 0, 1);

    // DOWN, P=5 then period rewritten to 2 mid-period; irq set/clear ordering
    pwmclkdiv_onoff = CLKDIV_OFF;
    count_mode      = CNT_DOWN;
    period          = 16'd5;
    irq_clr         = 1'b1;
    step("irq_clr_idle", 16'd0, 0, 0, 0, 0, 0);
    irq_clr   = 1'b0;
    pwm_onoff = PWM_ON;
    step("dn_load5", 16'd5, 1, 0, 1, 0, 0);
    step("dn_4", 16'd4, 1, 0, 0, 0, 0);
    step("dn_3", 16'd3, 1, 0, 0, 0, 0);
    period = 16'd2;
    step("dn_2_old_p", 16'd2, 1, 0, 0, 0, 0);
    step("dn_1", 16'd1, 1, 0, 0, 0, 0);
    irq_clr = 1'b1;
    step("dn_0_set_wins", 16'd0, 1, 1, 0, 1, 1);
    step("dn_load2_clr", 16'd2, 1, 0, 1, 0, 0);
    irq_clr = 1'b0;
    step("dn_1b", 16'd1, 1, 0, 0, 0, 0);
    step("dn_0b", 16'd0, 1, 1, 0, 1, 1);

    // UP, P=5, switch to HOLD mid-period
    pwm_onoff  = PWM_OFF;
    irq_clr    = 1'b1;
    int_onoff  = INT_OFF;
    count_mode = CNT_UP;
    period     = 16'd5;
    step("hold_idle", 16'd0, 0, 0, 0, 0, 0);
    irq_clr   = 1'b0;
    pwm_onoff = PWM_ON;
    step("hold_up_1", 16'd1, 0, 0, 0, 0, 0);
    count_mode = CNT_HOLD;
    for (int k = 2; k <= 4; k++) step("hold_up_run", 16'(k), 0, 0, 0, 0, 0);
    step("hold_up_5_max", 16'd5, 0, 0, 1, 0, 0);
    step("hold_up_0_zero", 16'd0, 0, 1, 0, 1, 0);
    repeat (3) step("hold_frozen", 16'd0, 0, 0, 0, 0, 0);

    // Reset mid-run at carrier=7, then P=0 behaviour from the reset period_act
    pwm_onoff  = PWM_OFF;
    count_mode = CNT_UP;
    period     = 16'd10;
    step("rst_idle", 16'd0, 0, 0, 0, 0, 0);
    pwm_onoff = PWM_ON;
    for (int k = 1; k <= 7; k++) step("rst_run", 16'(k), 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    step("rst_mid", 16'd0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step("p0_zero", 16'd0, 0, 1, 0, 1, 0);
    step("after_p0_1", 16'd1, 0, 0, 0, 0, 0);
    pwm_onoff = PWM_OFF;
    step("final_off", 16'd0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
